mdu_hilo_ctrl: RTL and testbench

//  Multiply/divide sequencer for the HI/LO register pair. Sits in EX beside the
//  HI/LO register file and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX.

---
 rtl/mdu_hilo_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mdu_hilo_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo_ctrl.sv
// rtl/mdu_hilo_ctrl.sv - HI/LO multiply/divide sequencer with a radix-2 restoring divider
// Optional MDU_ITER_MUL_EN: MULT/MULTU use the iterative RUN/DONE path instead of a combinational multiplier.
module mdu_hilo_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             op_valid,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic             stall,
   output logic             busy,
   output logic             hi_we,
   output logic             lo_we,
   output logic [WIDTH-1:0] hi_wdata,
   output logic [WIDTH-1:0] lo_wdata
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem, quo, dvs;
   logic             neg_q, neg_r;

   logic is_mthi, is_mtlo, is_mul, is_div, start, op_signed, rs_neg, rt_neg;
   logic [WIDTH-1:0] rs_mag, rt_mag;

   assign is_mthi   = op_valid && (op == 3'b101);
   assign is_mtlo   = op_valid && (op == 3'b110);
   assign is_mul    = op_valid && ((op == 3'b001) || (op == 3'b010));
   assign is_div    = op_valid && ((op == 3'b011) || (op == 3'b100));
   assign op_signed = (op == 3'b001) || (op == 3'b011);
   assign rs_neg    = op_signed && rs_data[WIDTH-1];
   assign rt_neg    = op_signed && rt_data[WIDTH-1];
   assign rs_mag    = rs_neg ? -rs_data : rs_data;
   assign rt_mag    = rt_neg ? -rt_data : rt_data;

   // Restoring divide step: remainder sits in rem, dividend bits shift out of quo.
   logic [WIDTH:0]   shl, diff;
   logic [WIDTH-1:0] div_rem, div_quo;
   assign shl     = {rem, quo[WIDTH-1]};
   assign diff    = shl - {1'b0, dvs};
   assign div_rem = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
   assign div_quo = {quo[WIDTH-2:0], ~diff[WIDTH]};

`ifdef MDU_ITER_MUL_EN
   logic             mul_r;
   logic [WIDTH:0]   mul_sum;
   logic [2*WIDTH-1:0] mul_res;
   assign start   = is_div || is_mul;
   assign mul_sum = {1'b0, rem} + (quo[0] ? {1'b0, dvs} : '0);
   assign mul_res = neg_q ? -{rem, quo} : {rem, quo};
`else
   logic [2*WIDTH-1:0] ext_rs, ext_rt, prod;
   assign start  = is_div;
   assign ext_rs = {{WIDTH{rs_neg}}, rs_data};
   assign ext_rt = {{WIDTH{rt_neg}}, rt_data};
   assign prod   = ext_rs * ext_rt;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (cnt == CW'(WIDTH-1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
`ifdef MDU_ITER_MUL_EN
         mul_r <= 1'b0;
`endif
      end else if (state == IDLE && start && !flush) begin
         cnt   <= '0;
         rem   <= '0;
         neg_q <= rs_neg ^ rt_neg;
         neg_r <= rs_neg;
`ifdef MDU_ITER_MUL_EN
         mul_r <= is_mul;
         quo   <= is_mul ? rt_mag : rs_mag;
         dvs   <= is_mul ? rs_mag : rt_mag;
`else
         quo   <= rs_mag;
         dvs   <= rt_mag;
`endif
      end else if (state == RUN) begin
         cnt <= cnt + CW'(1);
`ifdef MDU_ITER_MUL_EN
         if (mul_r) begin
            rem <= mul_sum[WIDTH:1];
            quo <= {mul_sum[0], quo[WIDTH-1:1]};
         end else begin
            rem <= div_rem;
            quo <= div_quo;
         end
`else
         rem <= div_rem;
         quo <= div_quo;
`endif
      end
   end

   always_comb begin
      stall    = 1'b0;
      hi_we    = 1'b0;
      lo_we    = 1'b0;
      hi_wdata = '0;
      lo_wdata = '0;
      busy     = !rst && (state != IDLE);
      if (!rst && !flush) begin
         case (state)
            IDLE: begin
               if (is_mthi) begin
                  hi_we    = 1'b1;
                  hi_wdata = rs_data;
               end
               if (is_mtlo) begin
                  lo_we    = 1'b1;
                  lo_wdata = rs_data;
               end
`ifndef MDU_ITER_MUL_EN
               if (is_mul) begin
                  hi_we                = 1'b1;
                  lo_we                = 1'b1;
                  {hi_wdata, lo_wdata} = prod;
               end
`endif
               if (start) stall = 1'b1;
            end
            RUN: stall = 1'b1;
            DONE: begin
               hi_we = 1'b1;
               lo_we = 1'b1;
`ifdef MDU_ITER_MUL_EN
               if (mul_r) begin
                  {hi_wdata, lo_wdata} = mul_res;
               end else begin
                  hi_wdata = neg_r ? -rem : rem;
                  lo_wdata = neg_q ? -quo : quo;
               end
`else
               hi_wdata = neg_r ? -rem : rem;
               lo_wdata = neg_q ? -quo : quo;
`endif
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// tb/tb_mdu_hilo_ctrl.sv - directed and randomized bench for mdu_hilo_ctrl
module tb_mdu_hilo_ctrl;
   logic        clk = 1'b0;
   logic        rst, flush, op_valid;
   logic [2:0]  op;
   logic [31:0] rs_data, rt_data;
   logic        stall, busy, hi_we, lo_we;
   logic [31:0] hi_wdata, lo_wdata;

   int checks = 0;
   int errors = 0;

   mdu_hilo_ctrl #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op(op),
      .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .busy(busy),
      .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference {hi,lo} for MULT/MULTU from full-precision integer arithmetic
   function automatic logic [63:0] ref_mul(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      longint unsigned ua, ub;
      if (o == 3'b001) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      ua = longint'(a);
      ub = longint'(b);
      return ua * ub;
   endfunction

   // Reference {hi,lo} for DIV/DIVU: truncating division on magnitudes, sign fix-up after
   function automatic logic [63:0] ref_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      bit an, bn;
      longint unsigned am, bm, q, r;
      logic [31:0] lo, hi;
      an = (o == 3'b011) && a[31];
      bn = (o == 3'b011) && b[31];
      am = an ? (64'h1_0000_0000 - longint'(a)) & 64'hFFFF_FFFF : longint'(a);
      bm = bn ? (64'h1_0000_0000 - longint'(b)) & 64'hFFFF_FFFF : longint'(b);
      if (bm == 0) begin
         q = 64'hFFFF_FFFF;
         r = am;
      end else begin
         q = am / bm;
         r = am % bm;
      end
      lo = (an != bn) ? 32'(64'h1_0000_0000 - q) : 32'(q);
      hi = an ? 32'(64'h1_0000_0000 - r) : 32'(r);
      return {hi, lo};
   endfunction

   task automatic single_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
      #1;
      chk("single_stall", stall, 0);
      if (o == 3'b101) begin
         chk("mthi_we", {hi_we, lo_we}, 2'b10);
         chk("mthi_data", hi_wdata, a);
      end else if (o == 3'b110) begin
         chk("mtlo_we", {hi_we, lo_we}, 2'b01);
         chk("mtlo_data", lo_wdata, a);
      end else begin
         chk("mul_we", {hi_we, lo_we}, 2'b11);
         chk("mul_data", {hi_wdata, lo_wdata}, ref_mul(o, a, b));
      end
      tick();
      op_valid = 1'b0;
   endtask

   task automatic div_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      int stalls = 0;
      bit spur = 0;
      op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
      #1;
      for (int g = 0; g < 100; g++) begin
         if (!stall) break;
         stalls++;
         if (hi_we || lo_we) spur = 1;
         tick();
         #1;
      end
      chk("div_stall_cycles", stalls, 33);
      chk("div_no_early_write", spur, 0);
      chk("div_done_we", {hi_we, lo_we}, 2'b11);
      chk("div_done_busy", busy, 1);
      chk("div_result", {hi_wdata, lo_wdata}, ref_div(o, a, b));
      op_valid = 1'b0;
      tick();
      #1;
      chk("div_idle_after", {busy, hi_we, lo_we}, 0);
   endtask

   task automatic watch_quiet(input string tag);
      bit spur = 0;
      for (int i = 0; i < 40; i++) begin
         if (hi_we || lo_we || busy) spur = 1;
         tick();
      end
      chk(tag, spur, 0);
   endtask

   initial begin
      logic [2:0]  o;
      logic [31:0] a, b;

      rst = 1'b1; flush = 1'b0; op_valid = 1'b1; op = 3'b101;
      rs_data = 32'h12345678; rt_data = 32'h0;
      #1;
      chk("rst_strobes", {hi_we, lo_we, stall, busy}, 0);
      chk("rst_wdata", {hi_wdata, lo_wdata}, 0);
      op_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_busy", busy, 0);

      single_op(3'b101, 32'h12345678, 32'h0);
      single_op(3'b110, 32'hCAFEF00D, 32'h0);
      single_op(3'b001, 32'hFFFFFFFE, 32'h3);
      chk("mult_known", ref_mul(3'b001, 32'hFFFFFFFE, 32'h3), 64'hFFFFFFFF_FFFFFFFA);
      single_op(3'b010, 32'hFFFFFFFE, 32'h3);
      chk("multu_known", ref_mul(3'b010, 32'hFFFFFFFE, 32'h3), 64'h00000002_FFFFFFFA);

      div_op(3'b011, 32'hFFFFFFF9, 32'h2);
      div_op(3'b011, 32'h80000000, 32'hFFFFFFFF);
      div_op(3'b100, 32'h5, 32'h0);
      div_op(3'b011, 32'hFFFFFFF9, 32'h0);

      for (int i = 0; i < 24; i++) begin
         o = (i % 3 == 0) ? 3'($urandom_range(5, 6)) : 3'($urandom_range(1, 2));
         single_op(o, $urandom, $urandom);
      end
      for (int i = 0; i < 12; i++) begin
         o = 3'($urandom_range(3, 4));
         a = $urandom;
         b = (i % 4 == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
         div_op(o, a, b);
      end

      // flush partway through RUN aborts the divide with no write
      op_valid = 1'b1; op = 3'b100; rs_data = 32'd100; rt_data = 32'd7;
      #1;
      chk("flush_accept_stall", stall, 1);
      repeat (10) tick();
      flush = 1'b1; op_valid = 1'b0;
      #1;
      chk("flush_forced", {stall, hi_we, lo_we}, 0);
      tick();
      flush = 1'b0;
      #1;
      chk("flush_idle", busy, 0);
      watch_quiet("flush_no_write");
      div_op(3'b100, 32'd100, 32'd7);

      // flush with a new op in IDLE drops it
      flush = 1'b1; op_valid = 1'b1; op = 3'b011; rs_data = $urandom; rt_data = 32'd3;
      #1;
      chk("flush_new_div", {stall, hi_we, lo_we}, 0);
      op = 3'b101;
      #1;
      chk("flush_mthi", {hi_we, lo_we}, 0);
      tick();
      flush = 1'b0; op_valid = 1'b0;
      #1;
      chk("flush_drop_idle", busy, 0);

      // reset mid-RUN
      op_valid = 1'b1; op = 3'b011; rs_data = 32'd1000; rt_data = 32'd9;
      repeat (5) tick();
      rst = 1'b1; op_valid = 1'b0;
      #1;
      chk("rst_run_outputs", {stall, busy, hi_we, lo_we}, 0);
      chk("rst_run_wdata", {hi_wdata, lo_wdata}, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("rst_run_idle", busy, 0);
      watch_quiet("rst_no_write");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
